// File: rtl/lc3_int_ctrl.sv
// lc3_int_ctrl: 8-source prioritised interrupt controller for an LC-3 core.
// Each source has edge-detected pending capture and a programmable 3-bit
// priority. The winner is offered to the control unit through a
// three-state handshake (IDLE -> REQ -> ACK).
// Optional feature: define LC3_INTC_MASK_EN to add per-source enable bits
// that are written from cfg_mask.
module lc3_int_ctrl #(
  parameter logic [7:0] VEC_BASE = 8'h80,
  parameter logic [2:0] PRI_RST  = 3'd4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irq_req,
  input  logic [2:0] psr_pl,
  input  logic       int_ack,
  input  logic       cfg_we,
  input  logic [2:0] cfg_sel,
  input  logic [2:0] cfg_pri,
  input  logic       cfg_mask,
  output logic       int_out,
  output logic [7:0] intv,
  output logic [7:0] src_ack
);

  typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

  state_t      state_q, state_d;
  logic [7:0]  irq_q, irq_d;
  logic [7:0]  pend_q, pend_d;
  logic        int_out_q, int_out_d;
  logic [7:0]  intv_q, intv_d;
  logic [7:0]  src_ack_q, src_ack_d;
  logic [2:0]  win_idx_q, win_idx_d;
  logic [2:0]  win_pri_q, win_pri_d;

  logic [7:0]  rise;
  logic [7:0]  src_en;
  logic [7:0]  elig;
  logic [23:0] pri_flat;
  logic [7:0]  pend_clr;
  logic        arb_found;
  logic [2:0]  arb_idx;
  logic [2:0]  arb_pri;

`ifdef LC3_INTC_MASK_EN
  logic [7:0] mask_q, mask_d;

  // Mask register update from the configuration port
  always_comb begin
    mask_d = mask_q;
    if (cfg_we) begin
      mask_d[cfg_sel] = cfg_mask;
    end
  end

  // Mask register storage; every source enabled out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '1;
    end else begin
      mask_q <= mask_d;
    end
  end

  assign src_en = mask_q;
`else
  // Without the mask feature every source is permanently enabled.
  logic unused_cfg_mask;
  assign unused_cfg_mask = cfg_mask;
  assign src_en          = '1;
`endif

  // Per-source priority register and eligibility term
  for (genvar gi = 0; gi < 8; gi++) begin : g_src
    logic [2:0] pri_q, pri_d;

    // Priority register write when this source is selected
    always_comb begin
      pri_d = pri_q;
      if (cfg_we && (cfg_sel == 3'(gi))) begin
        pri_d = cfg_pri;
      end
    end

    // Priority register storage
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pri_q <= PRI_RST;
      end else begin
        pri_q <= pri_d;
      end
    end

    assign pri_flat[gi*3 +: 3] = pri_q;
    assign elig[gi]            = pend_q[gi] & src_en[gi] & (pri_q > psr_pl);
  end

  assign rise  = irq_req & ~irq_q;
  assign irq_d = irq_req;

  // Arbiter: highest priority wins; scanning upward with a strict compare
  // keeps the lowest index on ties
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = 3'd0;
    arb_pri   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (elig[i] && (!arb_found || (pri_flat[i*3 +: 3] > arb_pri))) begin
        arb_found = 1'b1;
        arb_idx   = 3'(i);
        arb_pri   = pri_flat[i*3 +: 3];
      end
    end
  end

  // Offer FSM next-state and output logic
  always_comb begin
    state_d   = state_q;
    int_out_d = int_out_q;
    intv_d    = intv_q;
    src_ack_d = '0;
    win_idx_d = win_idx_q;
    win_pri_d = win_pri_q;
    pend_clr  = '0;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          state_d   = REQ;
          int_out_d = 1'b1;
          intv_d    = VEC_BASE + {5'b0, arb_idx};
          win_idx_d = arb_idx;
          win_pri_d = arb_pri;
        end
      end
      REQ: begin
        // Acknowledge beats withdrawal when both happen together
        if (int_ack) begin
          state_d   = ACK;
          int_out_d = 1'b0;
          src_ack_d = 8'b1 << win_idx_q;
          pend_clr  = 8'b1 << win_idx_q;
        end else if (psr_pl >= win_pri_q) begin
          state_d   = IDLE;
          int_out_d = 1'b0;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        int_out_d = 1'b0;
      end
    endcase
    // A new edge on the serviced source in the same cycle is not lost
    pend_d = (pend_q & ~pend_clr) | rise;
  end

  // State, pending and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      irq_q     <= '0;
      pend_q    <= '0;
      int_out_q <= 1'b0;
      intv_q    <= 8'h00;
      src_ack_q <= '0;
      win_idx_q <= 3'd0;
      win_pri_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq_d;
      pend_q    <= pend_d;
      int_out_q <= int_out_d;
      intv_q    <= intv_d;
      src_ack_q <= src_ack_d;
      win_idx_q <= win_idx_d;
      win_pri_q <= win_pri_d;
    end
  end

  assign int_out = int_out_q;
  assign intv    = intv_q;
  assign src_ack = src_ack_q;

endmodule

// File: tb/tb_lc3_int_ctrl.sv
// Self-checking bench for lc3_int_ctrl. Expected vectors are queued when a
// source is pulsed and popped when the controller raises int_out.
// The mask scenario runs only when LC3_INTC_MASK_EN is defined.
module tb_lc3_int_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq_req;
  logic [2:0] psr_pl;
  logic       int_ack;
  logic       cfg_we;
  logic [2:0] cfg_sel;
  logic [2:0] cfg_pri;
  logic       cfg_mask;
  logic       int_out;
  logic [7:0] intv;
  logic [7:0] src_ack;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] cur_exp;

  lc3_int_ctrl #(.VEC_BASE(8'h80), .PRI_RST(3'd4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq_req  (irq_req),
    .psr_pl   (psr_pl),
    .int_ack  (int_ack),
    .cfg_we   (cfg_we),
    .cfg_sel  (cfg_sel),
    .cfg_pri  (cfg_pri),
    .cfg_mask (cfg_mask),
    .int_out  (int_out),
    .intv     (intv),
    .src_ack  (src_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [2:0] sel, input logic [2:0] pri, input logic msk);
    cfg_we   = 1'b1;
    cfg_sel  = sel;
    cfg_pri  = pri;
    cfg_mask = msk;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] srcs);
    irq_req = srcs;
    tick();
    irq_req = 8'h00;
  endtask

  // Wait (bounded) for an offer, then compare against the oldest expectation
  task automatic wait_offer(input string tag, input int exp_lat);
    int n;
    n = 0;
    while (int_out !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    check({tag, "_offer"}, 32'(int_out), 32'd1);
    if (exp_lat >= 0) check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    if (exp_q.size() > 0) begin
      cur_exp = exp_q.pop_front();
      check({tag, "_intv"}, 32'(intv), 32'(cur_exp));
    end else begin
      check({tag, "_queue_empty"}, 32'd0, 32'd1);
    end
  endtask

  task automatic do_ack(input string tag);
    logic [7:0] exp_ack;
    exp_ack = 8'h01 << (cur_exp - 8'h80);
    int_ack = 1'b1;
    tick();
    check({tag, "_src_ack"}, 32'(src_ack), 32'(exp_ack));
    check({tag, "_int_out_lo"}, 32'(int_out), 32'd0);
    int_ack = 1'b0;
    tick();
    check({tag, "_src_ack_1cyc"}, 32'(src_ack), 32'd0);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick();
      check(tag, 32'(int_out), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    irq_req  = 8'h00;
    psr_pl   = 3'd0;
    int_ack  = 1'b0;
    cfg_we   = 1'b0;
    cfg_sel  = 3'd0;
    cfg_pri  = 3'd0;
    cfg_mask = 1'b1;
    tick();
    tick();
    check("rst_int_out", 32'(int_out), 32'd0);
    check("rst_intv", 32'(intv), 32'h00);
    check("rst_src_ack", 32'(src_ack), 32'd0);
    rst_n = 1'b1;
    tick();

    // int_ack outside REQ has no effect
    int_ack = 1'b1;
    tick();
    check("ack_idle_src_ack", 32'(src_ack), 32'd0);
    int_ack = 1'b0;

    // Single source, basic latency and acknowledge
    exp_q.push_back(8'h80);
    pulse(8'h01);
    check("s1_not_yet", 32'(int_out), 32'd0);
    wait_offer("s1", 1);
    do_ack("s1");
    expect_quiet("s1_quiet", 2);

    // Equal priorities: lowest index first
    cfg(3'd3, 3'd6, 1'b1);
    cfg(3'd5, 3'd6, 1'b1);
    exp_q.push_back(8'h83);
    exp_q.push_back(8'h85);
    pulse(8'h28);
    wait_offer("s2a", 1);
    do_ack("s2a");
    wait_offer("s2b", 1);
    do_ack("s2b");

    // Priority must strictly exceed psr_pl
    psr_pl = 3'd4;
    pulse(8'h04);
    expect_quiet("s3_blocked", 3);
    psr_pl = 3'd3;
    exp_q.push_back(8'h82);
    wait_offer("s3", 1);
    do_ack("s3");
    psr_pl = 3'd0;

    // Withdraw keeps pending; ack beats withdraw
    exp_q.push_back(8'h80);
    pulse(8'h01);
    wait_offer("s4", 1);
    psr_pl = 3'd7;
    tick();
    check("s4_withdraw", 32'(int_out), 32'd0);
    psr_pl = 3'd0;
    exp_q.push_back(8'h80);
    wait_offer("s4_reoffer", 1);
    psr_pl  = 3'd7;
    int_ack = 1'b1;
    tick();
    check("s4_ack_wins", 32'(src_ack), 32'h01);
    int_ack = 1'b0;
    psr_pl  = 3'd0;
    tick();
    check("s4_src_ack_1cyc", 32'(src_ack), 32'd0);
    expect_quiet("s4_quiet", 2);

    // Reset in REQ abandons the offer immediately
    exp_q.push_back(8'h86);
    pulse(8'h40);
    wait_offer("s5", 1);
    #2;
    rst_n   = 1'b0;
    int_ack = 1'b1;
    #1;
    check("s5_rst_int_out", 32'(int_out), 32'd0);
    check("s5_rst_intv", 32'(intv), 32'h00);
    check("s5_rst_src_ack", 32'(src_ack), 32'd0);
    tick();
    check("s5_rst_src_ack_edge", 32'(src_ack), 32'd0);
    int_ack = 1'b0;
    tick();
    rst_n = 1'b1;
    expect_quiet("s5_after_rst", 3);
    check("s5_after_rst_src_ack", 32'(src_ack), 32'd0);

`ifdef LC3_INTC_MASK_EN
    // Masked source latches pending but is not offered until unmasked
    cfg(3'd1, 3'd4, 1'b0);
    pulse(8'h02);
    expect_quiet("s6_masked", 3);
    cfg(3'd1, 3'd4, 1'b1);
    exp_q.push_back(8'h81);
    wait_offer("s6", -1);
    do_ack("s6");
`endif

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
